exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl_pkg.sv | 30 +++
 rtl/exc_prio.sv | 40 ++++
 rtl/exc_ctrl.sv | 169 ++++++++++++++++
 tb/tb_exc_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared constants and types for the exception/eret commit controller.
package exc_ctrl_pkg;

    localparam logic [31:0] EX_VECTOR_DEF = 32'hBFC00380;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    typedef enum logic {
        EV_TRAP = 1'b0,
        EV_ERET = 1'b1
    } ev_e;

    // Only address-error exceptions report a faulting address.
    function automatic logic has_badvaddr(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/exc_prio.sv
// Combinational event selection for a committing WB instruction.
module exc_prio
    import exc_ctrl_pkg::*;
(
    input  logic       ws_valid,
    input  logic       ws_ex,
    input  logic [4:0] ws_excode,
    input  logic       ws_eret,
    input  logic       int_q,
    output logic       take,
    output ev_e        ev_type,
    output logic [4:0] code
);

    // Interrupt beats a synchronous exception, which beats eret.
    always_comb begin
        take    = 1'b0;
        ev_type = EV_TRAP;
        code    = EXC_INT;
        if (ws_valid) begin
            priority case (1'b1)
                int_q: begin
                    take = 1'b1;
                end
                ws_ex: begin
                    take = 1'b1;
                    code = ws_excode;
                end
                ws_eret: begin
                    take    = 1'b1;
                    ev_type = EV_ERET;
                end
                default: begin
                    take = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/eret commit controller: latches a WB event, pulses CP0, flushes, redirects IF.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_VECTOR = EX_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_valid,
    input  logic        ws_ex,
    input  logic [4:0]  ws_excode,
    input  logic        ws_bd,
    input  logic [31:0] ws_pc,
    input  logic [31:0] ws_badvaddr,
    input  logic        ws_pc_error,
    input  logic        ws_eret,
    input  logic [5:0]  hw_int,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic        ex_valid,
    output logic [4:0]  ex_code,
    output logic        ex_bd,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_badvaddr,
    output logic        ex_pc_error,
    output logic        eret,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    state_e      state_q, state_d;
    ev_e         ev_q, ev_d;
    logic        int_q, int_d;
    logic [4:0]  code_q, code_d;
    logic        bd_q, bd_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] bad_q, bad_d;
    logic        pe_q, pe_d;
    logic        ex_valid_q, ex_valid_d;
    logic        eret_q, eret_d;
    logic        flush_q, flush_d;
    logic        rv_q, rv_d;
    logic [31:0] rpc_q, rpc_d;

    logic        int_pending;
    logic        take;
    ev_e         sel_ev;
    logic [4:0]  sel_code;

    logic        unused_cp0;
    assign unused_cp0 = ^{cp0_status[31:16], cp0_status[7:2],
                          cp0_cause[31:16], cp0_cause[7:0]};

    // Masked pending interrupt, gated by IE and blocked while EXL is set.
    assign int_pending = (|((cp0_cause[15:8] | {hw_int, 2'b00})
                            & cp0_status[15:8]))
                         & cp0_status[0] & ~cp0_status[1];

    exc_prio u_prio (
        .ws_valid  (ws_valid),
        .ws_ex     (ws_ex),
        .ws_excode (ws_excode),
        .ws_eret   (ws_eret),
        .int_q     (int_q),
        .take      (take),
        .ev_type   (sel_ev),
        .code      (sel_code)
    );

    always_comb begin
        state_d    = state_q;
        ev_d       = ev_q;
        int_d      = int_pending;
        code_d     = code_q;
        bd_d       = bd_q;
        pc_d       = pc_q;
        bad_d      = bad_q;
        pe_d       = pe_q;
        ex_valid_d = 1'b0;
        eret_d     = 1'b0;
        flush_d    = flush_q;
        rv_d       = rv_q;
        rpc_d      = rpc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d    = ST_COMMIT;
                    ev_d       = sel_ev;
                    code_d     = sel_code;
                    bd_d       = ws_bd;
                    pc_d       = ws_pc;
                    pe_d       = ws_pc_error;
                    bad_d      = has_badvaddr(sel_code) ? ws_badvaddr
                                                        : 32'h0;
                    ex_valid_d = (sel_ev == EV_TRAP);
                    eret_d     = (sel_ev == EV_ERET);
                    flush_d    = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_FLUSH;
                flush_d = 1'b1;
                rv_d    = 1'b1;
                rpc_d   = (ev_q == EV_ERET) ? cp0_epc : EX_VECTOR;
            end
            ST_FLUSH: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                    flush_d = 1'b0;
                    rv_d    = 1'b0;
                    rpc_d   = 32'h0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                flush_d = 1'b0;
                rv_d    = 1'b0;
                rpc_d   = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            ev_q       <= EV_TRAP;
            int_q      <= 1'b0;
            code_q     <= 5'h0;
            bd_q       <= 1'b0;
            pc_q       <= 32'h0;
            bad_q      <= 32'h0;
            pe_q       <= 1'b0;
            ex_valid_q <= 1'b0;
            eret_q     <= 1'b0;
            flush_q    <= 1'b0;
            rv_q       <= 1'b0;
            rpc_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            ev_q       <= ev_d;
            int_q      <= int_d;
            code_q     <= code_d;
            bd_q       <= bd_d;
            pc_q       <= pc_d;
            bad_q      <= bad_d;
            pe_q       <= pe_d;
            ex_valid_q <= ex_valid_d;
            eret_q     <= eret_d;
            flush_q    <= flush_d;
            rv_q       <= rv_d;
            rpc_q      <= rpc_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_code        = code_q;
    assign ex_bd          = bd_q;
    assign ex_pc          = pc_q;
    assign ex_badvaddr    = bad_q;
    assign ex_pc_error    = pe_q;
    assign eret           = eret_q;
    assign flush          = flush_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed and randomized bench for exc_ctrl against an event-timeline model.
module tb_exc_ctrl;
    import exc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        ws_valid = 0, ws_ex = 0, ws_bd = 0, ws_pc_error = 0, ws_eret = 0;
    logic [4:0]  ws_excode = 0;
    logic [31:0] ws_pc = 0, ws_badvaddr = 0;
    logic [5:0]  hw_int = 0;
    logic [31:0] cp0_status = 0, cp0_cause = 0, cp0_epc = 0;
    logic        redirect_ready = 1'b1;
    logic        ex_valid, ex_bd, ex_pc_error, eret, flush, redirect_valid;
    logic [4:0]  ex_code;
    logic [31:0] ex_pc, ex_badvaddr, redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    exc_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .ws_valid       (ws_valid),
        .ws_ex          (ws_ex),
        .ws_excode      (ws_excode),
        .ws_bd          (ws_bd),
        .ws_pc          (ws_pc),
        .ws_badvaddr    (ws_badvaddr),
        .ws_pc_error    (ws_pc_error),
        .ws_eret        (ws_eret),
        .hw_int         (hw_int),
        .cp0_status     (cp0_status),
        .cp0_cause      (cp0_cause),
        .cp0_epc        (cp0_epc),
        .ex_valid       (ex_valid),
        .ex_code        (ex_code),
        .ex_bd          (ex_bd),
        .ex_pc          (ex_pc),
        .ex_badvaddr    (ex_badvaddr),
        .ex_pc_error    (ex_pc_error),
        .eret           (eret),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: age counts cycles since an event was accepted (0 = no event in flight).
    int          age = 0;
    bit          m_intq = 0;
    bit          m_trap = 0;
    logic [4:0]  m_code = 0;
    logic [31:0] m_pc = 0, m_bad = 0, m_rpc = 0;
    bit          m_bd = 0, m_pe = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            age = 0; m_intq = 0; m_rpc = 0;
        end else begin
            bit ip;
            ip = (((cp0_cause[15:8] | {hw_int, 2'b00}) & cp0_status[15:8]) != 0)
                 && cp0_status[0] && !cp0_status[1];
            if (age == 0) begin
                if (ws_valid && (m_intq || ws_ex || ws_eret)) begin
                    m_trap = m_intq || ws_ex;
                    m_code = m_intq ? 5'd0 : (ws_ex ? ws_excode : 5'd0);
                    m_pc   = ws_pc;
                    m_bd   = ws_bd;
                    m_pe   = ws_pc_error;
                    m_bad  = (m_code == 5'd4 || m_code == 5'd5) ? ws_badvaddr : 32'h0;
                    age    = 1;
                end
            end else if (age == 1) begin
                m_rpc = m_trap ? 32'hBFC00380 : cp0_epc;
                age   = 2;
            end else if (redirect_ready) begin
                age = 0;
            end else begin
                age = age + 1;
            end
            m_intq = ip;
        end
    end

    always @(posedge clk) begin
        #1;
        if (resetn) begin
            chk("ex_valid", {31'h0, ex_valid}, {31'h0, age == 1 && m_trap});
            chk("eret", {31'h0, eret}, {31'h0, age == 1 && !m_trap});
            chk("flush", {31'h0, flush}, {31'h0, age >= 1});
            chk("redirect_valid", {31'h0, redirect_valid}, {31'h0, age >= 2});
            chk("redirect_pc", redirect_pc, (age >= 2) ? m_rpc : 32'h0);
            if (age == 1 && m_trap) begin
                chk("ex_code", {27'h0, ex_code}, {27'h0, m_code});
                chk("ex_pc", ex_pc, m_pc);
                chk("ex_bd", {31'h0, ex_bd}, {31'h0, m_bd});
                chk("ex_pc_error", {31'h0, ex_pc_error}, {31'h0, m_pe});
                chk("ex_badvaddr", ex_badvaddr, m_bad);
            end
        end
    end

    task automatic drv(input logic ex, input logic [4:0] code, input logic [31:0] pc,
                       input logic [31:0] bad, input logic er);
        ws_valid = 1; ws_ex = ex; ws_excode = code; ws_pc = pc;
        ws_badvaddr = bad; ws_eret = er; ws_bd = 0; ws_pc_error = 0;
    endtask

    task automatic idle_ws();
        ws_valid = 0; ws_ex = 0; ws_eret = 0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_flags"}, {26'h0, ex_valid, eret, flush, redirect_valid, ex_bd, ex_pc_error}, 32'h0);
        chk({nm, "_rpc"}, redirect_pc, 32'h0);
        chk({nm, "_code"}, {27'h0, ex_code}, 32'h0);
        chk({nm, "_pc"}, ex_pc, 32'h0);
        chk({nm, "_bad"}, ex_badvaddr, 32'h0);
    endtask

    logic [4:0] codes [7];

    initial begin
        codes = '{EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV};
        #1 resetn = 0;
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("reset");
        @(negedge clk) resetn = 1;

        // syscall trap
        @(negedge clk) drv(1, EXC_SYS, 32'h1000, 0, 0);
        @(posedge clk) #1;
        chk("d025_exv", {31'h0, ex_valid}, 32'h1);
        chk("d025_code", {27'h0, ex_code}, 32'h8);
        chk("d025_pc", ex_pc, 32'h1000);
        @(negedge clk) idle_ws();
        @(posedge clk) #1;
        chk("d025_rv", {31'h0, redirect_valid}, 32'h1);
        chk("d025_rpc", redirect_pc, 32'hBFC00380);
        @(posedge clk) #1;
        chk("d025_idle", {31'h0, flush}, 32'h0);

        // interrupt wins over exception; no event while ws_valid=0
        @(negedge clk) begin cp0_status = 32'h0000FF01; hw_int = 6'h01; end
        @(posedge clk) #1;
        @(posedge clk) #1;
        chk("d019_noev", {31'h0, flush}, 32'h0);
        @(negedge clk) drv(1, EXC_OV, 32'h1100, 0, 0);
        @(posedge clk) #1;
        chk("d026_exv", {31'h0, ex_valid}, 32'h1);
        chk("d026_code", {27'h0, ex_code}, 32'h0);
        @(negedge clk) begin idle_ws(); cp0_status = 0; hw_int = 0; end
        repeat (3) @(posedge clk);

        // eret with back-pressure
        @(negedge clk) begin redirect_ready = 0; cp0_epc = 32'h2004; drv(0, 0, 32'h1200, 0, 1); end
        @(posedge clk) #1;
        chk("d027_eret", {31'h0, eret}, 32'h1);
        chk("d027_noex", {31'h0, ex_valid}, 32'h0);
        @(negedge clk) idle_ws();
        @(posedge clk) #1;
        chk("d027_eret1", {31'h0, eret}, 32'h0);
        chk("d027_rpc", redirect_pc, 32'h2004);
        @(negedge clk) cp0_epc = 32'hDEAD0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            chk("d027_hold", {30'h0, flush, redirect_valid}, 32'h3);
            chk("d027_rpc_hold", redirect_pc, 32'h2004);
        end
        @(negedge clk) redirect_ready = 1;
        @(posedge clk) #1;
        chk("d027_done", {30'h0, flush, redirect_valid}, 32'h0);

        // badvaddr masking
        @(negedge clk) drv(1, EXC_ADEL, 32'h1300, 32'h3, 0);
        @(posedge clk) #1;
        chk("d028_bad4", ex_badvaddr, 32'h3);
        @(negedge clk) idle_ws();
        repeat (2) @(posedge clk);
        @(negedge clk) drv(1, EXC_RI, 32'h1400, 32'h3, 0);
        @(posedge clk) #1;
        chk("d028_bad10", ex_badvaddr, 32'h0);
        @(negedge clk) idle_ws();
        repeat (2) @(posedge clk);

        // second exception during FLUSH is ignored
        @(negedge clk) begin redirect_ready = 0; drv(1, EXC_SYS, 32'h1500, 0, 0); end
        @(posedge clk) #1;
        chk("d029_first", {31'h0, ex_valid}, 32'h1);
        @(negedge clk) drv(1, EXC_BP, 32'h1504, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            chk("d029_none", {31'h0, ex_valid}, 32'h0);
        end
        @(negedge clk) begin idle_ws(); redirect_ready = 1; end
        repeat (2) @(posedge clk);

        // reset during FLUSH
        @(negedge clk) begin redirect_ready = 0; drv(1, EXC_SYS, 32'h1600, 0, 0); end
        @(posedge clk);
        @(negedge clk) idle_ws();
        @(posedge clk);
        @(negedge clk) resetn = 0;
        #1 chk_all_zero("d030_rst");
        @(negedge clk) begin resetn = 1; redirect_ready = 1; end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            chk("d030_quiet", {29'h0, ex_valid, eret, flush}, 32'h0);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 249) == 0) begin
                resetn = 0;
                @(negedge clk);
                resetn = 1;
            end
            ws_valid       = ($urandom_range(0, 1) == 1);
            ws_ex          = ($urandom_range(0, 4) == 0);
            ws_excode      = codes[$urandom_range(0, 6)];
            ws_eret        = ($urandom_range(0, 6) == 0);
            ws_bd          = $urandom_range(0, 1);
            ws_pc_error    = ($urandom_range(0, 7) == 0);
            ws_pc          = $urandom;
            ws_badvaddr    = $urandom;
            redirect_ready = ($urandom_range(0, 4) < 3);
            cp0_epc        = $urandom;
            hw_int         = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'h0;
            cp0_cause      = ($urandom_range(0, 9) == 0) ? $urandom : 32'h0;
            cp0_status     = {16'h0, 8'($urandom), 6'h0,
                              ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0)};
        end
        @(negedge clk) idle_ws();
        repeat (4) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
